regfile_read_streamer: RTL and testbench

- Reader end of the team's 32-bit register array: takes the flattened outputs of all registers plus a snoop of the array's write port.
- Serves burst read requests (base index + count) as a stream of words over a valid/ready handshake.
- Used for register dumps to the debug/test interface and for multi-register reads without a combinational mux on the critical path.

---
 rtl/regfile_read_streamer.sv | 142 ++++++++++++++
 tb/tb_regfile_read_streamer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_streamer.sv
// Purpose : streams burst reads (base index + count) out of the flattened 32-bit register array.
// Latency : first word is registered one cycle after the request is accepted, then one word per cycle.
// Backpr. : single output slot; a held word stays frozen while rsp_ready is low, and the burst pauses.
//
// Ports:
//   clock, reset        - rising-edge clock, asynchronous active-low reset
//   reg_bus             - all register outputs, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   snoop_we/addr/data  - copy of the array write port, forwarded into words loaded that cycle
//   req_valid/ready     - burst request handshake; req_addr = first index, req_count = words - 1
//   rsp_valid/ready     - word handshake; rsp_data/rsp_addr/rsp_last describe the held word
//   busy                - high while a burst is streaming or a word is still held
//
// Build option: define REGFILE_STREAM_ZERO_REG_EN to make index 0 always read as zero.
module regfile_read_streamer #(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_bus,
    input  logic                           snoop_we,
    input  logic [ADDR_WIDTH-1:0]          snoop_addr,
    input  logic [DATA_WIDTH-1:0]          snoop_data,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    input  logic [ADDR_WIDTH-1:0]          req_count,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic [ADDR_WIDTH-1:0]          rsp_addr,
    output logic                           rsp_last,
    output logic                           busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   cur_addr_q,  cur_addr_d;
    logic [ADDR_WIDTH-1:0]   remaining_q, remaining_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q,  rsp_data_d;
    logic [ADDR_WIDTH-1:0]   rsp_addr_q,  rsp_addr_d;
    logic                    rsp_last_q,  rsp_last_d;

    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]   rd_value;
    logic                    slot_free;

    // Unflatten the bus so the read mux is a plain array index.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_unpack
        assign regs[g] = reg_bus[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Value of the register at cur_addr as it will be after this cycle's write.
    always_comb begin
        rd_value = regs[cur_addr_q];
        if (snoop_we && (snoop_addr == cur_addr_q)) begin
            rd_value = snoop_data;
        end
`ifdef REGFILE_STREAM_ZERO_REG_EN
        if (cur_addr_q == '0) begin
            rd_value = '0;
        end
`endif
    end

    // The slot can take a new word when empty or when its word leaves this cycle.
    assign slot_free = !rsp_valid_q || rsp_ready;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_last_d  = rsp_last_q;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // A request may be taken while the previous last word still waits;
                // STREAM will not overwrite that word until it is consumed.
                if (req_valid) begin
                    cur_addr_d  = req_addr;
                    remaining_d = req_count;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                if (slot_free) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rd_value;
                    rsp_addr_d  = cur_addr_q;
                    rsp_last_d  = (remaining_q == '0);
                    cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - ADDR_WIDTH'(1);
                    if (remaining_q == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_last  = rsp_last_q;
    assign busy      = (state_q != IDLE) || rsp_valid_q;

endmodule

// File: tb/tb_regfile_read_streamer.sv
// Purpose : self-checking bench for regfile_read_streamer with a word scoreboard.
// Latency : expects the first word one clock edge after the accepting edge.
// Backpr. : drives rsp_ready low to stall; held words must not change.
module tb_regfile_read_streamer;

    localparam int NR = 32;
    localparam int DW = 32;
    localparam int AW = 5;

    logic                 clock;
    logic                 reset;
    logic [NR*DW-1:0]     reg_bus;
    logic                 snoop_we;
    logic [AW-1:0]        snoop_addr;
    logic [DW-1:0]        snoop_data;
    logic                 req_valid;
    logic                 req_ready;
    logic [AW-1:0]        req_addr;
    logic [AW-1:0]        req_count;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DW-1:0]        rsp_data;
    logic [AW-1:0]        rsp_addr;
    logic                 rsp_last;
    logic                 busy;

    logic [DW-1:0]        regs [NR];

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          last;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_rx     = 0;

    for (genvar g = 0; g < NR; g++) begin : g_bus
        assign reg_bus[g*DW +: DW] = regs[g];
    end

    regfile_read_streamer #(.NUM_REGS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .reg_bus    (reg_bus),
        .snoop_we   (snoop_we),
        .snoop_addr (snoop_addr),
        .snoop_data (snoop_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_count  (req_count),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_addr   (rsp_addr),
        .rsp_last   (rsp_last),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DW-1:0] model_value(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = regs[a];
`ifdef REGFILE_STREAM_ZERO_REG_EN
        if (a == '0) v = '0;
`endif
        return v;
    endfunction

    task automatic push_exp(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic l);
        exp_t e;
        e.data = d;
        e.addr = a;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic push_burst(input logic [AW-1:0] a, input logic [AW-1:0] c);
        logic [AW-1:0] idx;
        for (int k = 0; k <= int'(c); k++) begin
            idx = a + AW'(k);
            push_exp(model_value(idx), idx, (k == int'(c)));
        end
    endtask

    // Returns one time unit after the accepting edge.
    task automatic send_req(input logic [AW-1:0] a, input logic [AW-1:0] c);
        logic acc;
        int   n;
        req_valid = 1'b1;
        req_addr  = a;
        req_count = c;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            acc = req_ready;
            tick();
            n++;
        end
        req_valid = 1'b0;
        if (!acc) chk("req_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (busy || exp_q.size() != 0) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    // Scoreboard: a word is taken at the coming rising edge when valid&&ready here.
    always @(negedge clock) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {59'd0, rsp_addr}, 64'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
                chk("rsp_addr", 64'(rsp_addr), 64'(e.addr));
                chk("rsp_last", 64'(rsp_last), 64'(e.last));
                n_rx++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_count  = '0;
        rsp_ready  = 1'b0;
        snoop_we   = 1'b0;
        snoop_addr = '0;
        snoop_data = '0;
        for (int i = 0; i < NR; i++) regs[i] = 32'(i) * 32'h11111111;

        // Reset state
        #12;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_rsp_data",  64'(rsp_data),  64'd0);
        chk("rst_rsp_addr",  64'(rsp_addr),  64'd0);
        chk("rst_rsp_last",  64'(rsp_last),  64'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        // Single word with latency and busy
        regs[5]   = 32'hDEADBEEF;
        rsp_ready = 1'b1;
        push_burst(5'd5, 5'd0);
        send_req(5'd5, 5'd0);
        chk("single_busy", 64'(busy), 64'd1);
        chk("single_not_yet", 64'(rsp_valid), 64'd0);
        tick();
        chk("single_latency", 64'(rsp_valid), 64'd1);
        tick();
        chk("single_done_vld", 64'(rsp_valid), 64'd0);
        chk("single_done_busy", 64'(busy), 64'd0);
        wait_idle();

        // Wrap-around, one word per cycle
        push_burst(5'd30, 5'd3);
        send_req(5'd30, 5'd3);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("wrap_stream_vld", 64'(rsp_valid), 64'd1);
            tick();
        end
        chk("wrap_gap_vld", 64'(rsp_valid), 64'd0);
        wait_idle();

        // Index 0 with a non-zero bus value
        regs[0] = 32'hAAAA5555;
        push_burst(5'd0, 5'd0);
        send_req(5'd0, 5'd0);
        wait_idle();

        // Backpressure with a snooped write to the held register
        rsp_ready = 1'b0;
        push_burst(5'd2, 5'd2);
        send_req(5'd2, 5'd2);
        tick();
        chk("bp_loaded", 64'(rsp_valid), 64'd1);
        snoop_we   = 1'b1;
        snoop_addr = 5'd2;
        snoop_data = 32'hCAFEF00D;
        tick();
        snoop_we = 1'b0;
        regs[2]  = 32'hCAFEF00D;
        chk("bp_hold_data", 64'(rsp_data), 64'h22222222);
        tick();
        tick();
        chk("bp_hold_vld",  64'(rsp_valid), 64'd1);
        chk("bp_hold_addr", 64'(rsp_addr),  64'd2);
        rsp_ready = 1'b1;
        wait_idle();

        // Forwarding on the load cycle
        push_exp(32'h12345678, 5'd7, 1'b1);
        send_req(5'd7, 5'd0);
        snoop_we   = 1'b1;
        snoop_addr = 5'd7;
        snoop_data = 32'h12345678;
        tick();
        snoop_we = 1'b0;
        regs[7]  = 32'h12345678;
        wait_idle();

`ifdef REGFILE_STREAM_ZERO_REG_EN
        push_exp(32'h0, 5'd0, 1'b1);
`else
        push_exp(32'h0BADF00D, 5'd0, 1'b1);
`endif
        send_req(5'd0, 5'd0);
        snoop_we   = 1'b1;
        snoop_addr = 5'd0;
        snoop_data = 32'h0BADF00D;
        tick();
        snoop_we = 1'b0;
        regs[0]  = 32'h0BADF00D;
        wait_idle();

        // Request accepted while the last word drains
        rsp_ready = 1'b0;
        push_burst(5'd10, 5'd0);
        send_req(5'd10, 5'd0);
        tick();
        push_burst(5'd20, 5'd0);
        send_req(5'd20, 5'd0);
        chk("drain_hold_vld",  64'(rsp_valid), 64'd1);
        chk("drain_hold_addr", 64'(rsp_addr),  64'd10);
        tick();
        chk("drain_hold_addr2", 64'(rsp_addr), 64'd10);
        rsp_ready = 1'b1;
        tick();
        chk("drain_next_vld",  64'(rsp_valid), 64'd1);
        chk("drain_next_addr", 64'(rsp_addr),  64'd20);
        wait_idle();

        // Reset in the middle of a full dump
        for (int i = 0; i < NR; i++) regs[i] = 32'(i) * 32'h11111111;
        base = n_rx;
        push_burst(5'd0, 5'd31);
        send_req(5'd0, 5'd31);
        n = 0;
        while (n_rx < base + 4 && n < 50) begin
            tick();
            n++;
        end
        chk("rst_mid_words_seen", 64'(n_rx - base), 64'd4);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_vld",  64'(rsp_valid), 64'd0);
        chk("rst_mid_busy", 64'(busy),      64'd0);
        exp_q.delete();
        tick();
        reset = 1'b1;
        chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
        for (int k = 0; k < 10; k++) tick();
        chk("rst_mid_no_words", 64'(n_rx - base), 64'd4);
        chk("rst_mid_idle_vld", 64'(rsp_valid),   64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
